// File: rtl/pipeif_fetch.sv
// IF stage: PC register, next-PC select and single-outstanding fetch.
// Delivers ins/pc4 with a wir strobe so stalls never drop or repeat words.
module pipeif_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wpc,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] ins,
    output logic        wir
);

    typedef enum logic {
        REQ  = 1'b0,
        HAVE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] ibuf;
    logic [31:0] npc;
    logic        consume;
    logic        capture;

    assign pc4       = pc + 32'd4;
    assign imem_addr = {pc[31:2], 2'b00};

    always_comb begin
        npc = pc4;
        unique case (pcsource)
            2'b00: npc = pc4;
            2'b01: npc = bpc;
            2'b10: npc = rpc;
            2'b11: npc = jpc;
        endcase
    end

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        wir      = 1'b0;
        ins      = ibuf;
        capture  = 1'b0;
        unique case (state)
            REQ: begin
                imem_req = 1'b1;
                wir      = imem_ready;
                if (imem_ready) begin
                    // bypass the response straight to IF/ID
                    ins = imem_rdata;
                    if (!wpc) begin
                        capture  = 1'b1;
                        state_nx = HAVE;
                    end
                end
            end
            HAVE: begin
                wir = 1'b1;
                if (wpc) state_nx = REQ;
            end
        endcase
    end

    assign consume = wir & wpc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc    <= {RESET_PC[31:2], 2'b00};
            ibuf  <= 32'd0;
        end else begin
            state <= state_nx;
            if (consume) pc <= {npc[31:2], 2'b00};
            if (capture) ibuf <= imem_rdata;
        end
    end

    a_pc_align : assert property (
        @(posedge clk) disable iff (rst) pc[1:0] == 2'b00);

    a_addr_stable : assert property (
        @(posedge clk) disable iff (rst)
        imem_req && !imem_ready |=> $stable(imem_addr));

    // a held response is always visible until it is consumed
    a_have_valid : assert property (
        @(posedge clk) disable iff (rst)
        state == HAVE |-> wir && !imem_req);

endmodule

// File: tb/tb_pipeif_fetch.sv
// Randomised and directed checks of pipeif_fetch against a
// transaction-level model of the fetch stage.
module tb_pipeif_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        wpc;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    logic        imem_req, wir;
    logic [31:0] imem_addr, pc, pc4, ins;
    logic        w_req, w_wir;
    logic [31:0] w_addr, w_pc, w_pc4, w_ins;

    int n_assert = 0;
    int n_fail   = 0;

    // model state: current fetch pc, whether an instruction is held
    logic [31:0] mpc;
    logic        mhave;
    logic [31:0] mins;

    always #5 clk = ~clk;

    pipeif_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .wpc(wpc), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc(pc), .pc4(pc4), .ins(ins), .wir(wir)
    );

    pipeif_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .wpc(wpc), .pcsource(pcsource),
        .bpc(bpc), .rpc(rpc), .jpc(jpc),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .pc(w_pc), .pc4(w_pc4), .ins(w_ins), .wir(w_wir)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy,
                         input logic w, input logic [1:0] ps);
        rst        = r;
        imem_ready = rdy;
        wpc        = w;
        pcsource   = ps;
        imem_rdata = mpc ^ 32'hA5A5_A5A5;
    endtask

    // one clock: check outputs mid-cycle, then advance the model
    task automatic cycle();
        logic        ewir;
        logic [31:0] tgt;
        @(negedge clk);
        if (!rst) begin
            ewir = mhave | imem_ready;
            chk("pc", pc, mpc);
            chk("pc4", pc4, mpc + 32'd4);
            chk("addr", imem_addr, mpc);
            chk("req", {31'd0, imem_req}, {31'd0, !mhave});
            chk("wir", {31'd0, wir}, {31'd0, ewir});
            if (ewir)
                chk("ins", ins, mhave ? mins : imem_rdata);
        end
        @(posedge clk);
        if (rst) begin
            mpc   = 32'd0;
            mhave = 1'b0;
            mins  = 32'd0;
        end else if ((mhave | imem_ready) && wpc) begin
            case (pcsource)
                2'b00:   tgt = mpc + 32'd4;
                2'b01:   tgt = bpc;
                2'b10:   tgt = rpc;
                default: tgt = jpc;
            endcase
            mpc   = tgt & ~32'd3;
            mhave = 1'b0;
        end else if (!mhave && imem_ready) begin
            mhave = 1'b1;
            mins  = imem_rdata;
        end
        #1;
    endtask

    initial begin
        mpc = 0; mhave = 0; mins = 0;
        bpc = 32'h100; rpc = 32'h203; jpc = 32'h400;
        drive(1, 1, 1, 2'b00);
        cycle();
        // reset taken while a response was presented
        drive(0, 0, 1, 2'b00);
        @(negedge clk);
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc4", pc4, 32'h4);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_wir", {31'd0, wir}, 32'd0);
        chk("rst_ins", ins, 32'd0);
        @(posedge clk); #1;

        // zero-wait stream
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 1, 2'b00);
            chk("zw_addr", mpc, 32'(i * 4));
            cycle();
        end

        // two wait states per request
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 2'b00); cycle();
            drive(0, 0, 1, 2'b00); cycle();
            drive(0, 1, 1, 2'b00); cycle();
        end
        chk("ws_pc", pc, 32'h1C);

        // stall holding a response at pc=8
        drive(1, 0, 1, 2'b00); cycle();
        drive(0, 1, 1, 2'b00); cycle();
        drive(0, 1, 1, 2'b00); cycle();
        drive(0, 1, 0, 2'b00); cycle();
        for (int i = 0; i < 4; i++) begin
            drive(0, i[0], 0, 2'(i));
            cycle();
        end
        chk("st_pc", pc, 32'h8);
        chk("st_ins", ins, 32'h8 ^ 32'hA5A5_A5A5);
        drive(0, 0, 1, 2'b00); cycle();
        chk("st_next", imem_addr, 32'hC);

        // redirects
        drive(0, 1, 1, 2'b01); cycle();
        chk("br", imem_addr, 32'h100);
        drive(0, 1, 1, 2'b10); cycle();
        chk("jr", imem_addr, 32'h200);
        drive(0, 1, 1, 2'b11); cycle();
        chk("j", imem_addr, 32'h400);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bpc = $urandom; rpc = $urandom; jpc = $urandom;
            drive(($urandom_range(0, 60) == 0), 1'($urandom),
                  1'($urandom_range(0, 3) != 0), 2'($urandom));
            cycle();
        end

        // wrap-around on the high-reset instance
        drive(1, 0, 1, 2'b00); cycle();
        drive(0, 1, 1, 2'b00);
        @(negedge clk); chk("wr0", w_addr, 32'hFFFF_FFF8);
        @(posedge clk); #1;
        @(negedge clk); chk("wr1", w_addr, 32'hFFFF_FFFC);
        chk("wr_pc4", w_pc4, 32'h0);
        @(posedge clk); #1;
        @(negedge clk); chk("wr2", w_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
